// File: rtl/chng_det_pkg.sv
// Shared types for the change-event scheduler.
//   fsm_e     : output-port state (IDLE: nothing offered, OFFER: evt_* valid)
//   evt_t     : one offered event {channel id, edge type, overwrite flag}
//   EDGE_RISE / EDGE_FALL : encoding of the edge-type bit
package chng_det_pkg;

  // Wide enough for the largest supported channel count (16).
  localparam int unsigned CH_W = 4;

  typedef enum logic [0:0] {
    IDLE,
    OFFER
  } fsm_e;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            rise;
    logic            ovf;
  } evt_t;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

endpackage

// File: rtl/chng_det_slot.sv
// Per-channel change detector with a single-entry pending slot.
//   clk, rst : clock, synchronous active-high reset
//   sig      : monitored level (already synchronous)
//   en       : detection enable; when low the slot empties
//   drain    : arbiter takes the slot contents this cycle
//   pend     : slot holds an undelivered edge
//   rise     : edge type held in the slot
//   ovf      : an older edge in the slot was overwritten
//   drop     : pulse, an edge was overwritten this cycle
module chng_det_slot
  import chng_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic en,
  input  logic drain,
  output logic pend,
  output logic rise,
  output logic ovf,
  output logic drop
);

  logic sig_q;
  logic pend_q, pend_d;
  logic rise_q, rise_d;
  logic ovf_q, ovf_d;
  logic chg;
  logic chg_type;

  assign chg      = (sig ^ sig_q) & en;
  assign chg_type = (sig & ~sig_q) ? EDGE_RISE : EDGE_FALL;

  always_comb begin
    pend_d = pend_q;
    rise_d = rise_q;
    ovf_d  = ovf_q;
    drop   = 1'b0;
    if (!en) begin
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (chg) begin
      rise_d = chg_type;
      pend_d = 1'b1;
      if (!pend_q || drain) begin
        // Slot empty, or emptied this very cycle: a fresh event, nothing lost.
        ovf_d = 1'b0;
      end else begin
        ovf_d = 1'b1;
        drop  = 1'b1;
      end
    end else if (drain) begin
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  // sig_q tracks sig even in reset so the level at reset release is not an edge.
  always_ff @(posedge clk) begin
    sig_q <= sig;
    if (rst) begin
      pend_q <= 1'b0;
      rise_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      rise_q <= rise_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend = pend_q;
  assign rise = rise_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/chng_evt_arb.sv
// Multi-channel change-event scheduler: per-channel edge detect and pending
// slot, round-robin arbitration onto one registered valid/ready event port.
//   clk, rst   : clock, synchronous active-high reset
//   sig        : monitored signals
//   en_mask    : per-channel detection enable
//   evt_valid  : event offered (registered)
//   evt_ready  : consumer accepts
//   evt_ch     : channel id of offered event
//   evt_rise   : 1 = rising edge, 0 = falling edge
//   evt_ovf    : earlier edge on this channel was overwritten
//   pend       : per-channel pending flags
//   drop_cnt   : saturating count of overwritten events
module chng_evt_arb
  import chng_det_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned IDW  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  sig,
  input  logic [N_CH-1:0]  en_mask,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_ch,
  output logic             evt_rise,
  output logic             evt_ovf,
  output logic [N_CH-1:0]  pend,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [N_CH-1:0]  slot_pend, slot_rise, slot_ovf, slot_drop, drain, req;
  fsm_e             state_q, state_d;
  evt_t             evt_q, evt_d;
  logic [IDW-1:0]   rr_q, rr_d, base, gnt, nxt_ptr;
  logic             any_req, load, xfer;
  logic [CNT_W-1:0] drop_q, drop_d;
  int unsigned      idx;

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
    chng_det_slot u_slot (
      .clk   (clk),
      .rst   (rst),
      .sig   (sig[i]),
      .en    (en_mask[i]),
      .drain (drain[i]),
      .pend  (slot_pend[i]),
      .rise  (slot_rise[i]),
      .ovf   (slot_ovf[i]),
      .drop  (slot_drop[i])
    );
    assign drain[i] = load && (gnt == IDW'(i));
  end

  // A slot being cleared by a disabled channel is not offered.
  assign req       = slot_pend & en_mask;
  assign evt_valid = (state_q == OFFER);
  assign xfer      = evt_valid & evt_ready;
  assign nxt_ptr   = (evt_q.ch == CH_W'(N_CH - 1)) ? '0 : IDW'(evt_q.ch + CH_W'(1));
  // In OFFER a reload only happens on transfer, so search from the post-transfer pointer.
  assign base      = (state_q == OFFER) ? nxt_ptr : rr_q;

  // First requesting channel at or after base, wrapping.
  always_comb begin
    any_req = 1'b0;
    gnt     = '0;
    idx     = 0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      idx = 32'(base) + off;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!any_req && req[IDW'(idx)]) begin
        any_req = 1'b1;
        gnt     = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    evt_d   = evt_q;
    rr_d    = rr_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) load = 1'b1;
      end
      OFFER: begin
        if (xfer) begin
          rr_d = nxt_ptr;
          if (any_req) load = 1'b1;
          else         state_d = IDLE;
        end
      end
    endcase
    if (load) begin
      evt_d.ch   = CH_W'(gnt);
      evt_d.rise = slot_rise[gnt];
      evt_d.ovf  = slot_ovf[gnt];
      state_d    = OFFER;
    end
  end

  always_comb begin
    drop_d = drop_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (slot_drop[i] && (drop_d != '1)) drop_d = drop_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      evt_q   <= '0;
      rr_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

  assign evt_ch   = evt_q.ch[IDW-1:0];
  assign evt_rise = evt_q.rise;
  assign evt_ovf  = evt_q.ovf;
  assign pend     = slot_pend;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_chng_evt_arb.sv
module tb_chng_evt_arb;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig, en_mask;
  logic       evt_valid, evt_ready, evt_rise, evt_ovf;
  logic [1:0] evt_ch;
  logic [3:0] pend;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  chng_evt_arb #(.N_CH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .en_mask   (en_mask),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .evt_ovf   (evt_ovf),
    .pend      (pend),
    .drop_cnt  (drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: event queue semantics from the behavioural rules.
  bit         m_valid, m_rise, m_ovf;
  int         m_ch, m_ptr, m_drop;
  bit         m_pend[N], m_type[N], m_povf[N];
  logic [3:0] m_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clk(input logic r, input logic [3:0] s, input logic [3:0] e,
                           input logic rdy);
    int  g, start;
    bit  search;
    bool_dummy: begin end
    if (r) begin
      m_valid = 0; m_ch = 0; m_rise = 0; m_ovf = 0; m_ptr = 0; m_drop = 0;
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_type[i] = 0; m_povf[i] = 0; end
    end else begin
      g = -1; search = 0; start = m_ptr;
      if (!m_valid) begin
        search = 1;
      end else if (rdy) begin
        m_ptr = (m_ch + 1) % N;
        start = m_ptr;
        search = 1;
      end
      if (search) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (start + k) % N;
          if (g < 0 && m_pend[c] && e[c]) g = c;
        end
        if (g >= 0) begin
          m_valid = 1; m_ch = g; m_rise = m_type[g]; m_ovf = m_povf[g];
        end else begin
          m_valid = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        bit drained, chg;
        drained = (i == g);
        chg = e[i] && (s[i] != m_prev[i]);
        if (!e[i]) begin
          m_pend[i] = 0; m_povf[i] = 0;
        end else if (chg) begin
          m_type[i] = s[i];
          if (!m_pend[i] || drained) begin
            m_pend[i] = 1; m_povf[i] = 0;
          end else begin
            m_povf[i] = 1;
            if (m_drop < 255) m_drop++;
          end
        end else if (drained) begin
          m_pend[i] = 0; m_povf[i] = 0;
        end
      end
    end
    m_prev = s;
  endtask

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Apply inputs for one clock, advance the model, compare #1 after the edge.
  task automatic step(input logic r, input logic [3:0] s, input logic [3:0] e, input logic rdy);
    rst = r; sig = s; en_mask = e; evt_ready = rdy;
    @(posedge clk);
    model_clk(r, s, e, rdy);
    #1;
    chk("m_valid", evt_valid, m_valid);
    if (m_valid) begin
      chk("m_ch", evt_ch, m_ch);
      chk("m_rise", evt_rise, m_rise);
      chk("m_ovf", evt_ovf, m_ovf);
    end
    chk("m_pend", pend, m_pend_vec());
    chk("m_drop", drop_cnt, m_drop);
  endtask

  typedef struct {
    logic       r;
    logic [3:0] s;
    logic       rdy;
    logic       ev;
    logic [1:0] ech;
    logic       erise;
    logic       eovf;
    logic [3:0] epend;
  } vec_t;

  vec_t tv[13];
  int   seen;

  initial begin
    rst = 1'b1; sig = 4'h0; en_mask = 4'hF; evt_ready = 1'b0;

    // Cycle-by-cycle vectors: all-channel burst from pointer 0, then single events.
    tv[0]  = '{1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0};
    tv[1]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'hF};
    tv[2]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'hE};
    tv[3]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'hC};
    tv[4]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'h8};
    tv[5]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 4'h0};
    tv[6]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0};
    tv[7]  = '{1'b0, 4'hB, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h4};
    tv[8]  = '{1'b0, 4'hB, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 4'h0};
    tv[9]  = '{1'b0, 4'hB, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0};
    tv[10] = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h4};
    tv[11] = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'h0};
    tv[12] = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0};

    for (int i = 0; i < 13; i++) begin
      step(tv[i].r, tv[i].s, 4'hF, tv[i].rdy);
      chk($sformatf("tv%0d_valid", i), evt_valid, tv[i].ev);
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_ch", i), evt_ch, tv[i].ech);
        chk($sformatf("tv%0d_rise", i), evt_rise, tv[i].erise);
        chk($sformatf("tv%0d_ovf", i), evt_ovf, tv[i].eovf);
      end
      chk($sformatf("tv%0d_pend", i), pend, tv[i].epend);
      chk($sformatf("tv%0d_drop", i), drop_cnt, 0);
    end

    // Level present at reset release is not an event.
    step(1'b1, 4'hA, 4'hF, 1'b0);
    step(1'b1, 4'hA, 4'hF, 1'b0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_pend", pend, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'hA, 4'hF, 1'b1);
      if (evt_valid) seen++;
    end
    chk("quiet_valid_cnt", seen, 0);
    chk("quiet_drop", drop_cnt, 0);

    // Overwrite while ch1's first event is held.
    step(1'b1, 4'h0, 4'hF, 1'b0);
    step(1'b0, 4'h2, 4'hF, 1'b0);
    step(1'b0, 4'h2, 4'hF, 1'b0);
    chk("ow_first_ch", evt_ch, 1);
    step(1'b0, 4'h0, 4'hF, 1'b0);
    step(1'b0, 4'h2, 4'hF, 1'b0);
    step(1'b0, 4'h2, 4'hF, 1'b0);
    chk("ow_hold_valid", evt_valid, 1);
    chk("ow_hold_ch", evt_ch, 1);
    chk("ow_hold_rise", evt_rise, 1);
    chk("ow_hold_ovf", evt_ovf, 0);
    chk("ow_drop", drop_cnt, 1);
    step(1'b0, 4'h2, 4'hF, 1'b1);
    for (int n = 0; n < 4 && !evt_valid; n++) step(1'b0, 4'h2, 4'hF, 1'b0);
    chk("ow_next_valid", evt_valid, 1);
    chk("ow_next_ch", evt_ch, 1);
    chk("ow_next_rise", evt_rise, 1);
    chk("ow_next_ovf", evt_ovf, 1);

    // Round-robin wrap: pointer left at 3, ch0 and ch3 pending.
    step(1'b1, 4'h0, 4'hF, 1'b1);
    step(1'b0, 4'h4, 4'hF, 1'b1);
    step(1'b0, 4'h4, 4'hF, 1'b1);
    chk("rr_ch2", evt_ch, 2);
    step(1'b0, 4'h4, 4'hF, 1'b1);
    step(1'b0, 4'hD, 4'hF, 1'b0);
    for (int n = 0; n < 4 && !evt_valid; n++) step(1'b0, 4'hD, 4'hF, 1'b0);
    chk("rr_first", evt_ch, 3);
    step(1'b0, 4'hD, 4'hF, 1'b1);
    chk("rr_second_valid", evt_valid, 1);
    chk("rr_second", evt_ch, 0);

    // Drop counter saturation: hold an offer, toggle ch3 repeatedly.
    step(1'b1, 4'h0, 4'hF, 1'b0);
    step(1'b0, 4'h1, 4'hF, 1'b0);
    step(1'b0, 4'h1, 4'hF, 1'b0);
    for (int t = 1; t <= 300; t++) begin
      step(1'b0, (t % 2) ? 4'h9 : 4'h1, 4'hF, 1'b0);
      if (t == 200) chk("sat_199", drop_cnt, 199);
      if (t == 256) chk("sat_255", drop_cnt, 255);
    end
    chk("sat_hold", drop_cnt, 255);

    // Reset mid-offer, then a masked channel.
    step(1'b1, 4'h0, 4'hF, 1'b0);
    step(1'b0, 4'h7, 4'hF, 1'b0);
    step(1'b0, 4'h7, 4'hF, 1'b0);
    chk("rmo_valid", evt_valid, 1);
    chk("rmo_pend", pend, 4'h6);
    step(1'b1, 4'h7, 4'hF, 1'b0);
    chk("rmo_cleared_valid", evt_valid, 0);
    chk("rmo_cleared_pend", pend, 0);
    step(1'b0, 4'h6, 4'hE, 1'b0);
    step(1'b0, 4'h7, 4'hE, 1'b0);
    chk("mask_pend", pend, 0);
    step(1'b0, 4'h5, 4'hE, 1'b0);
    chk("mask_other_pend", pend, 4'h2);
    step(1'b0, 4'h5, 4'hE, 1'b1);
    chk("mask_other_ch", evt_ch, 1);

    // Randomized traffic against the model.
    step(1'b1, 4'h0, 4'hF, 1'b1);
    begin
      logic [3:0] s, e;
      s = 4'h0; e = 4'hF;
      for (int c = 0; c < 3000; c++) begin
        for (int b = 0; b < N; b++) if ($urandom_range(3) == 0) s[b] = ~s[b];
        if ($urandom_range(31) == 0) e = 4'($urandom_range(15));
        step(($urandom_range(199) == 0), s, e, ($urandom_range(3) != 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
